// File: rtl/trigger_pkg.sv
// Shared widths, table entry layout and bank-select codes for the trigger sequencer.
// Top-level parameters default to the TRG_* values so the entry struct lines up.
package trigger_pkg;

  localparam int unsigned TRG_SDW = 32;
  localparam int unsigned TRG_SEW = 2;
  localparam int unsigned TRG_TEW = 10;
  localparam int unsigned TRG_TSW = 4;
  localparam int unsigned TRG_TCW = 16;
  localparam int unsigned TRG_BAW = TRG_TEW + TRG_TSW;
  localparam int unsigned TRG_BDW = 32;
  localparam int unsigned TRG_TDW = TRG_TSW + TRG_SEW + 1;

  // Bit positions inside bus_wselct.
  localparam int unsigned SEL_CTL = 0;
  localparam int unsigned SEL_TMO = 2;
  localparam int unsigned SEL_TBL = 3;

  typedef struct packed {
    logic               is_final;
    logic [TRG_SEW-1:0] evt;
    logic [TRG_TSW-1:0] nxt;
  } t_tbl_entry;

  // A zero timeout disables the check; otherwise fire on the sample that would make dwell reach tmo.
  function automatic logic tmo_hit(input logic [TRG_TCW-1:0] dwell,
                                   input logic [TRG_TCW-1:0] tmo);
    return (tmo != '0) && (dwell == (tmo - 1'b1));
  endfunction

endpackage

// File: rtl/trigger_table.sv
// Bus-writable transition table with an asynchronous read port.
// Contents are not reset; a write and a read of the same entry in one cycle returns the old value.
module trigger_table #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trigger_sequencer.sv
// Table-driven trigger sequencer: walks a state table on each accepted sample, tags the
// passing sample stream with table events, and latches a sticky final trigger.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned SDW = TRG_SDW,
  parameter int unsigned SEW = TRG_SEW,
  parameter int unsigned TEW = TRG_TEW,
  parameter int unsigned TSW = TRG_TSW,
  parameter int unsigned TCW = TRG_TCW,
  parameter int unsigned BAW = TEW + TSW,
  parameter int unsigned BDW = TRG_BDW
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  input  logic [3:0]     bus_wselct,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic [TEW-1:0] sti_tevts,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [SEW-1:0] sto_tevent,
  output logic [SDW-1:0] sto_tdata,
  output logic [TSW-1:0] sts_state,
  output logic           sts_trig,
  output logic           sts_tmo
);

  localparam int unsigned TDW = TSW + SEW + 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // A source never drops valid or changes payload while waiting; ready may change freely.
  // The sample port is a single output register: it accepts whenever that register is
  // empty or is being drained in the same cycle.

  logic           r_vld;
  logic [SDW-1:0] r_data;
  logic [SEW-1:0] r_evt;
  logic           r_tmo_pulse;
  logic [TSW-1:0] r_state;
  logic           r_armed;
  logic           r_trig;
  logic [TCW-1:0] r_dwell;
  logic [TCW-1:0] r_tmo [2**TSW];

  logic           w_bus_wr;
  logic           w_ctl_wr;
  logic           w_tmo_wr;
  logic           w_tbl_wr;
  logic           w_accept;
  logic           w_active;
  logic [TDW-1:0] w_rdata;
  t_tbl_entry     w_entry;
  logic [TCW-1:0] w_cur_tmo;
  logic [TSW-1:0] w_state_nxt;
  logic           w_armed_nxt;
  logic           w_trig_nxt;
  logic [TCW-1:0] w_dwell_nxt;
  logic           w_tmo_fire;
  logic [SEW-1:0] w_evt;
  logic           w_unused;

  assign bus_wready = rst;
  assign w_bus_wr   = bus_wvalid & bus_wready;
  assign w_ctl_wr   = w_bus_wr & bus_wselct[SEL_CTL];
  assign w_tmo_wr   = w_bus_wr & bus_wselct[SEL_TMO];
  assign w_tbl_wr   = w_bus_wr & bus_wselct[SEL_TBL];
  assign w_unused   = ^{bus_wdata[BDW-1:TCW], bus_wselct[1]};

  assign sti_tready = rst & (~r_vld | sto_tready);
  assign w_accept   = sti_tvalid & sti_tready;
  assign w_active   = r_armed & ~r_trig;

  trigger_table #(
    .AW (BAW),
    .DW (TDW)
  ) u_table (
    .clk     (clk),
    .i_we    (w_tbl_wr),
    .i_waddr (bus_waddr),
    .i_wdata (bus_wdata[TDW-1:0]),
    .i_raddr ({sti_tevts, r_state}),
    .o_rdata (w_rdata)
  );

  assign w_entry   = w_rdata;
  assign w_cur_tmo = r_tmo[r_state];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**TSW; i++) begin
        r_tmo[i] <= '0;
      end
    end else if (w_tmo_wr) begin
      r_tmo[bus_waddr[TSW-1:0]] <= bus_wdata[TCW-1:0];
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= '0;
      r_armed <= 1'b0;
      r_trig  <= 1'b0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= w_armed_nxt;
      r_trig  <= w_trig_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  // Next state: a real transition beats a timeout; the dwell counter saturates instead of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_trig_nxt  = r_trig;
    w_dwell_nxt = r_dwell;
    w_tmo_fire  = 1'b0;
    if (w_accept && w_active) begin
      if (w_entry.nxt != r_state) begin
        w_state_nxt = w_entry.nxt;
        w_dwell_nxt = '0;
      end else if (tmo_hit(r_dwell, w_cur_tmo)) begin
        w_state_nxt = '0;
        w_dwell_nxt = '0;
        w_tmo_fire  = 1'b1;
      end else if ((r_state != '0) && (r_dwell != '1)) begin
        w_dwell_nxt = r_dwell + 1'b1;
      end
      if (w_entry.is_final) begin
        w_trig_nxt = 1'b1;
      end
    end
    if (w_ctl_wr) begin
      w_armed_nxt = bus_wdata[0];
      if (bus_wdata[1]) begin
        w_state_nxt = '0;
        w_trig_nxt  = 1'b0;
        w_dwell_nxt = '0;
      end
    end
  end

  // Outputs: events are only emitted while the sequencer is live.
  always_comb begin
    w_evt = '0;
    if (w_active) begin
      w_evt = w_entry.evt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld       <= 1'b0;
      r_data      <= '0;
      r_evt       <= '0;
      r_tmo_pulse <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vld  <= 1'b1;
        r_data <= sti_tdata;
        r_evt  <= w_evt;
      end else if (sto_tready) begin
        r_vld <= 1'b0;
      end
      r_tmo_pulse <= w_tmo_fire;
    end
  end

  assign sto_tvalid = r_vld;
  assign sto_tdata  = r_data;
  assign sto_tevent = r_evt;
  assign sts_state  = r_state;
  assign sts_trig   = r_trig;
  assign sts_tmo    = r_tmo_pulse;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: vector tables of bus/sample operations with expected status,
// a scoreboard queue for the output stream, and hand-written backpressure/reset sequences.
module tb_trigger_sequencer;

  localparam int SDW = 32;
  localparam int SEW = 2;
  localparam int TEW = 10;
  localparam int TSW = 4;
  localparam int BAW = TEW + TSW;
  localparam int BDW = 32;
  localparam int W   = SEW + SDW;
  localparam int EV_S = 1;
  localparam int EV_O = 2;

  typedef enum logic [1:0] {OP_SMP, OP_CTL, OP_TMO, OP_TBL} op_e;
  typedef struct {
    op_e      op;
    int       a;
    int       d;
    logic [SEW-1:0] e_evt;
    logic [TSW-1:0] e_st;
    logic     e_tmo;
    logic     e_trig;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic [3:0]     bus_wselct;
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic [TEW-1:0] sti_tevts;
  logic           sto_tready;
  logic           sto_tvalid;
  logic [SEW-1:0] sto_tevent;
  logic [SDW-1:0] sto_tdata;
  logic [TSW-1:0] sts_state;
  logic           sts_trig;
  logic           sts_tmo;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];

  trigger_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus_wready (bus_wready),
    .bus_wvalid (bus_wvalid),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .bus_wselct (bus_wselct),
    .sti_tready (sti_tready),
    .sti_tvalid (sti_tvalid),
    .sti_tdata  (sti_tdata),
    .sti_tevts  (sti_tevts),
    .sto_tready (sto_tready),
    .sto_tvalid (sto_tvalid),
    .sto_tevent (sto_tevent),
    .sto_tdata  (sto_tdata),
    .sts_state  (sts_state),
    .sts_trig   (sts_trig),
    .sts_tmo    (sts_tmo)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: run did not finish, act=running req=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endfunction

  function automatic int ta(input int st, input int ev);
    return (ev << TSW) | st;
  endfunction

  function automatic void add(input op_e op, input int a, input int d, input int ee,
                              input int es, input int et, input int etr);
    vec_t v;
    v.op = op; v.a = a; v.d = d;
    v.e_evt = SEW'(ee); v.e_st = TSW'(es); v.e_tmo = 1'(et); v.e_trig = 1'(etr);
    vecs.push_back(v);
  endfunction

  // Scoreboard: one pop per output handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst && sto_tvalid && sto_tready) begin
      if (exp_q.size() == 0) begin
        chk("sto_unexpected", 64'({sto_tevent, sto_tdata}), 64'(0));
        failures += 0;
      end else begin
        chk("sto_sample", 64'({sto_tevent, sto_tdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic bus_wr(input logic [3:0] sel, input int a, input int d);
    bus_wvalid = 1'b1; bus_wselct = sel; bus_waddr = BAW'(a); bus_wdata = BDW'(d);
    @(posedge clk); #1;
    bus_wvalid = 1'b0; bus_wselct = 4'b0000;
  endtask

  task automatic send(input logic [TEW-1:0] ev, input logic [SEW-1:0] ee, input bit drop);
    int guard;
    guard = 0;
    sti_tvalid = 1'b1; sti_tevts = ev; sti_tdata = $urandom;
    @(negedge clk);
    while (!sti_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("send_tready", 64'(sti_tready), 64'(1));
    if (sti_tready) exp_q.push_back({ee, sti_tdata});
    else sti_tvalid = 1'b0;
    @(posedge clk); #1;
    if (drop) sti_tvalid = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_SMP:  send(TEW'(vecs[i].a), vecs[i].e_evt, 1'b1);
        OP_CTL:  bus_wr(4'b0001, 0, vecs[i].d);
        OP_TMO:  bus_wr(4'b0100, vecs[i].a, vecs[i].d);
        default: bus_wr(4'b1000, vecs[i].a, vecs[i].d);
      endcase
      chk($sformatf("%s%0d_state", tag, i), 64'(sts_state), 64'(vecs[i].e_st));
      chk($sformatf("%s%0d_tmo", tag, i), 64'(sts_tmo), 64'(vecs[i].e_tmo));
      chk($sformatf("%s%0d_trig", tag, i), 64'(sts_trig), 64'(vecs[i].e_trig));
    end
    vecs.delete();
  endtask

  initial begin
    rst = 1'b0; bus_wvalid = 1'b0; bus_waddr = '0; bus_wdata = '0; bus_wselct = 4'b0000;
    sti_tvalid = 1'b0; sti_tdata = '0; sti_tevts = '0; sto_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl_outs", 64'({bus_wready, sti_tready, sto_tvalid, sts_trig, sts_tmo}), 64'(0));
    chk("reset_data_outs", 64'({sto_tevent, sto_tdata, sts_state}), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("bus_wready_up", 64'(bus_wready), 64'(1));

    // Table: S (evts[0]), O (evts[1]), S; everything else stays put. Idle in state 1 emits evt 2.
    for (int s = 0; s < 4; s++) begin
      for (int ev = 0; ev < 3; ev++) begin
        bus_wr(4'b1000, ta(s, ev), ((s == 1 && ev == 0) ? 32'h20 : 32'h0) | s);
      end
    end
    bus_wr(4'b1000, ta(0, EV_S), 32'h01);
    bus_wr(4'b1000, ta(1, EV_O), 32'h02);
    bus_wr(4'b1000, ta(2, EV_S), 32'h13);

    // Basic sequence, then final-trigger latch
    add(OP_CTL, 0, 1, 0, 0, 0, 0);
    add(OP_SMP, 0, 0, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, EV_O, 0, 0, 2, 0, 0);
    add(OP_SMP, EV_S, 0, 1, 3, 0, 0);
    add(OP_CTL, 0, 3, 0, 0, 0, 0);
    add(OP_TBL, ta(2, EV_S), 32'h53, 0, 0, 0, 0);
    add(OP_SMP, 0, 0, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, EV_O, 0, 0, 2, 0, 0);
    add(OP_SMP, EV_S, 0, 1, 3, 0, 1);
    add(OP_SMP, EV_S, 0, 0, 3, 0, 1);
    add(OP_SMP, EV_O, 0, 0, 3, 0, 1);
    add(OP_SMP, EV_S, 0, 0, 3, 0, 1);
    add(OP_CTL, 0, 3, 0, 0, 0, 0);
    add(OP_TBL, ta(2, EV_S), 32'h13, 0, 0, 0, 0);
    // Timeout tmo[1]=3: fires on third idle sample, event still emitted
    add(OP_TMO, 1, 3, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, 0, 0, 2, 1, 0, 0);
    add(OP_SMP, 0, 0, 2, 1, 0, 0);
    add(OP_SMP, 0, 0, 2, 0, 1, 0);
    add(OP_SMP, EV_O, 0, 0, 0, 0, 0);
    // tmo=1 fires on every idle sample; tmo=0 never fires
    add(OP_TMO, 1, 1, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, 0, 0, 2, 0, 1, 0);
    add(OP_TMO, 1, 0, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(OP_SMP, 0, 0, 2, 1, 0, 0);
    // Transition beats a timeout due on the same sample
    add(OP_CTL, 0, 3, 0, 0, 0, 0);
    add(OP_TMO, 1, 3, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, 0, 0, 2, 1, 0, 0);
    add(OP_SMP, 0, 0, 2, 1, 0, 0);
    add(OP_SMP, EV_O, 0, 0, 2, 0, 0);
    add(OP_TMO, 1, 0, 0, 2, 0, 0);
    // Disarm in state 2, re-arm resumes
    add(OP_CTL, 0, 3, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, EV_O, 0, 0, 2, 0, 0);
    add(OP_CTL, 0, 0, 0, 2, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 2, 0, 0);
    add(OP_CTL, 0, 1, 0, 2, 0, 0);
    add(OP_SMP, EV_S, 0, 1, 3, 0, 0);
    add(OP_CTL, 0, 3, 0, 0, 0, 0);
    run_vecs("a");

    // Table write in the same cycle as a lookup of that entry: lookup sees the old entry
    bus_wvalid = 1'b1; bus_wselct = 4'b1000; bus_waddr = BAW'(ta(0, EV_S)); bus_wdata = 32'h32;
    send(TEW'(EV_S), 2'd0, 1'b1);
    bus_wvalid = 1'b0; bus_wselct = 4'b0000;
    chk("same_cycle_old_state", 64'(sts_state), 64'(1));
    bus_wr(4'b0001, 0, 3);
    send(TEW'(EV_S), 2'd3, 1'b1);
    chk("same_cycle_new_state", 64'(sts_state), 64'(2));
    bus_wr(4'b1000, ta(0, EV_S), 32'h01);
    bus_wr(4'b0001, 0, 3);

    // Back-to-back burst with a 5-cycle output stall
    fork
      begin
        for (int i = 0; i < 12; i++) send(TEW'(($urandom_range(0, 1) != 0) ? EV_O : 0), 2'd0, 1'b0);
        sti_tvalid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #2 sto_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_sti_tready", 64'(sti_tready), 64'(0));
          chk("stall_sto_tvalid", 64'(sto_tvalid), 64'(1));
        end
        @(posedge clk);
        #2 sto_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("burst_drained", 64'(exp_q.size()), 64'(0));
    chk("burst_state", 64'(sts_state), 64'(0));

    // Load trig, state and a timeout, then reset in the middle of traffic
    add(OP_TBL, ta(2, EV_S), 32'h53, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    add(OP_SMP, EV_O, 0, 0, 2, 0, 0);
    add(OP_SMP, EV_S, 0, 1, 3, 0, 1);
    add(OP_TMO, 1, 2, 0, 3, 0, 1);
    run_vecs("b");
    sto_tready = 1'b0;
    sti_tvalid = 1'b1; sti_tevts = '0; sti_tdata = $urandom | 32'h1;
    @(posedge clk); #1;
    sti_tdata = $urandom;
    @(posedge clk); #1;
    chk("pre_rst_sto_tvalid", 64'(sto_tvalid), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst_ctl_outs", 64'({bus_wready, sti_tready, sto_tvalid, sts_trig, sts_tmo}), 64'(0));
    chk("rst_data_outs", 64'({sto_tevent, sto_tdata, sts_state}), 64'(0));
    sti_tvalid = 1'b0; sto_tready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wready", 64'(bus_wready), 64'(1));
    chk("post_rst_trig", 64'(sts_trig), 64'(0));

    // After reset: unarmed, then timeout registers must be back to zero (no timeout fires)
    add(OP_SMP, EV_S, 0, 0, 0, 0, 0);
    add(OP_CTL, 0, 1, 0, 0, 0, 0);
    add(OP_SMP, EV_S, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(OP_SMP, 0, 0, 2, 1, 0, 0);
    add(OP_CTL, 0, 3, 0, 0, 0, 0);
    run_vecs("c");

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
